mul_share_arbiter: RTL and testbench

Round-robin scheduler sharing one combinational 8x8 approximate multiplier core among NREQ requesters. Each requester presents an operand pair with valid/ready, and the block grants one request per cycle. It drives the shared core through a registered operand stage and returns the 16-bit product with the requester's index through a registered, back-pressurable response port. It sits between the requesting datapaths and the multiplier core and is the only block that drives the core's inputs.

---
 rtl/mul_share_arbiter.sv | 111 +++++++++++
 tb/tb_mul_share_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one 8x8 multiplier core through a two-stage operand/response pipeline.
// Optional MUL_SHARE_ERRSTAT_EN adds err_cnt/err_sum statistics of the core against the exact product.
module mul_share_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [7:0]        mul_a,
  output logic [7:0]        mul_b,
  input  logic [15:0]       mul_p,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [15:0]       rsp_data,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       ops_cnt
`ifdef MUL_SHARE_ERRSTAT_EN
  ,
  output logic [15:0]       err_cnt,
  output logic [23:0]       err_sum
`endif
);
  logic [IDW-1:0]    r_ptr, r_s1_id, r_s2_id;
  logic              r_s1_v, r_s2_v;
  logic [7:0]        r_a, r_b;
  logic [15:0]       r_p, r_ops;
  logic              w_adv1, w_adv2, w_any, w_done;
  logic [IDW-1:0]    w_idx;
  logic [IDW:0]      w_j;
  logic [2*NREQ-1:0] w_rot;
  assign w_adv2 = !r_s2_v | rsp_ready;
  assign w_adv1 = !r_s1_v | w_adv2;
  assign w_done = r_s2_v & rsp_ready;
  // Rotate so bit k of w_rot is requester (ptr+k) mod NREQ; scanning downward leaves the nearest one.
  assign w_rot  = {req_valid, req_valid} >> r_ptr;
  always_comb begin
    w_any = 1'b0;
    w_idx = '0;
    w_j   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_rot[k]) begin
        w_any = 1'b1;
        w_idx = IDW'(w_j >= (IDW+1)'(NREQ) ? w_j - (IDW+1)'(NREQ) : w_j);
      end
    end
  end
  assign req_ready = (!RST && w_adv1 && w_any) ? NREQ'(1) << w_idx : '0;
  assign mul_a     = r_a;
  assign mul_b     = r_b;
  assign rsp_valid = r_s2_v;
  assign rsp_data  = r_p;
  assign rsp_id    = r_s2_id;
  assign ops_cnt   = r_ops;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ptr   <= '0;
      r_s1_v  <= 1'b0;
      r_s1_id <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_s2_v  <= 1'b0;
      r_s2_id <= '0;
      r_p     <= '0;
      r_ops   <= '0;
    end else begin
      if (w_done) r_ops <= r_ops + 16'd1;
      if (w_adv2) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_p     <= mul_p;
          r_s2_id <= r_s1_id;
        end
      end
      if (w_adv1) begin
        r_s1_v <= w_any;
        if (w_any) begin
          r_a     <= 8'(req_a >> {w_idx, 3'b000});
          r_b     <= 8'(req_b >> {w_idx, 3'b000});
          r_s1_id <= w_idx;
          r_ptr   <= (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + IDW'(1);
        end
      end
    end
  end
`ifdef MUL_SHARE_ERRSTAT_EN
  logic [15:0] r_exact, r_err_cnt, w_exact, w_diff;
  logic [23:0] r_err_sum;
  logic [24:0] w_sum;
  assign w_exact = 16'(r_a) * 16'(r_b);
  assign w_diff  = (r_exact >= r_p) ? r_exact - r_p : r_p - r_exact;
  assign w_sum   = {1'b0, r_err_sum} + {9'b0, w_diff};
  assign err_cnt = r_err_cnt;
  assign err_sum = r_err_sum;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_exact   <= '0;
      r_err_cnt <= '0;
      r_err_sum <= '0;
    end else begin
      if (w_adv2 && r_s1_v) r_exact <= w_exact;
      if (w_done && r_exact != r_p) r_err_cnt <= (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
      if (w_done) r_err_sum <= w_sum[24] ? 24'hFFFFFF : w_sum[23:0];
    end
  end
`endif
endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: directed checks of arbitration order, latency, backpressure and reset for mul_share_arbiter.
// The core model is exact except it ORs 0x0100 into the product when both operand MSBs are set.
module tb_mul_share_arbiter;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0, req_b = '0;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_p;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_id;
  logic [15:0] ops_cnt;
`ifdef MUL_SHARE_ERRSTAT_EN
  logic [15:0] err_cnt;
  logic [23:0] err_sum;
`endif
  int checks = 0;
  int errors = 0;

  mul_share_arbiter #(.NREQ(4), .IDW(3)) dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .ops_cnt(ops_cnt)
`ifdef MUL_SHARE_ERRSTAT_EN
    , .err_cnt(err_cnt), .err_sum(err_sum)
`endif
  );

  always #5 CLK = ~CLK;

  always_comb begin
    mul_p = 16'(mul_a) * 16'(mul_b);
    if (mul_a[7] && mul_b[7]) mul_p = mul_p | 16'h0100;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int g[7];
    logic [15:0] prod[4];
    g = '{3, 0, 1, 2, 3, 0, 1};
    prod = '{16'h0200, 16'h0231, 16'h0264, 16'h450F};
    req_valid = 4'hF;
    // reset held with every requester valid
    step();
    chk("rst_ready1", 32'(req_ready), 0);
    chk("rst_valid1", 32'(rsp_valid), 0);
    chk("rst_ops1", 32'(ops_cnt), 0);
    chk("rst_mula", 32'(mul_a), 0);
    step();
    chk("rst_ready2", 32'(req_ready), 0);
    chk("rst_valid2", 32'(rsp_valid), 0);
    chk("rst_ops2", 32'(ops_cnt), 0);
    chk("rst_data", 32'(rsp_data), 0);
    RST = 1'b0;
    #1;
    chk("first_grant", 32'(req_ready), 32'h1);
    req_valid = 4'h0;
    // single request from requester 2
    req_a = 32'h00050000;
    req_b = 32'h00030000;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = 4'h0;
    #1;
    chk("single_s1_a", 32'(mul_a), 32'h05);
    chk("single_s1_b", 32'(mul_b), 32'h03);
    chk("single_notyet", 32'(rsp_valid), 0);
    step();
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_id", 32'(rsp_id), 2);
    chk("single_data", 32'(rsp_data), 32'h000F);
    step();
    chk("single_ops", 32'(ops_cnt), 1);
    chk("single_drained", 32'(rsp_valid), 0);
    // all four continuously valid; ptr starts at 3
    req_a = 32'h83121110;
    req_b = 32'h85222120;
    req_valid = 4'hF;
    #1;
    chk("rr_ready_init", 32'(req_ready), 32'h8);
    for (int n = 0; n < 6; n++) begin
      step();
      chk($sformatf("rr_ready_%0d", n), 32'(req_ready), 32'(4'b1 << g[n+1]));
      if (n >= 1) begin
        chk($sformatf("rr_valid_%0d", n), 32'(rsp_valid), 1);
        chk($sformatf("rr_id_%0d", n), 32'(rsp_id), 32'(g[n-1]));
        chk($sformatf("rr_data_%0d", n), 32'(rsp_data), 32'(prod[g[n-1]]));
        chk($sformatf("rr_ops_%0d", n), 32'(ops_cnt), 32'(n));
      end
    end
    req_valid = 4'h0;
    step();
    chk("drain_id", 32'(rsp_id), 0);
    chk("drain_ops6", 32'(ops_cnt), 6);
    step();
    chk("drain_empty", 32'(rsp_valid), 0);
    chk("drain_ops7", 32'(ops_cnt), 7);
    // backpressure with requesters 1 and 3; ptr is now 1
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("bp_ready0", 32'(req_ready), 32'h2);
    step();
    chk("bp_ready1", 32'(req_ready), 32'h8);
    for (int n = 2; n <= 5; n++) begin
      step();
      chk($sformatf("bp_stall_ready_%0d", n), 32'(req_ready), 0);
      chk($sformatf("bp_valid_%0d", n), 32'(rsp_valid), 1);
      chk($sformatf("bp_id_%0d", n), 32'(rsp_id), 1);
      chk($sformatf("bp_data_%0d", n), 32'(rsp_data), 32'h0231);
      chk($sformatf("bp_ops_%0d", n), 32'(ops_cnt), 7);
    end
    rsp_ready = 1'b1;
    req_valid = 4'h0;
    step();
    chk("bp_rel_id", 32'(rsp_id), 3);
    chk("bp_rel_data", 32'(rsp_data), 32'h450F);
    chk("bp_rel_ops", 32'(ops_cnt), 8);
    step();
    chk("bp_rel_empty", 32'(rsp_valid), 0);
    chk("bp_rel_ops2", 32'(ops_cnt), 9);
    // reset while two products are in flight
    rsp_ready = 1'b0;
    req_valid = 4'b0110;
    step();
    step();
    chk("mid_full", 32'(rsp_valid), 1);
    chk("mid_id", 32'(rsp_id), 1);
    req_valid = 4'h0;
    RST = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 0);
    step();
    chk("mid_rst_valid", 32'(rsp_valid), 0);
    chk("mid_rst_ops", 32'(ops_cnt), 0);
    RST = 1'b0;
    step();
    chk("mid_no_rsp", 32'(rsp_valid), 0);
    chk("mid_ops_held", 32'(ops_cnt), 0);
    req_valid = 4'hF;
    #1;
    chk("mid_ptr0", 32'(req_ready), 32'h1);
    req_valid = 4'h0;
    step();
    chk("mid_idle", 32'(rsp_valid), 0);
`ifdef MUL_SHARE_ERRSTAT_EN
    req_a = 32'h000000FF;
    req_b = 32'h000000FF;
    req_valid = 4'b0001;
    step();
    req_valid = 4'h0;
    step();
    chk("err_data", 32'(rsp_data), 32'hFF01);
    chk("err_cnt_pre", 32'(err_cnt), 0);
    chk("err_sum_pre", 32'(err_sum), 0);
    step();
    chk("err_cnt", 32'(err_cnt), 1);
    chk("err_sum", 32'(err_sum), 32'h100);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
